// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 codes, FSM state type and access legality check for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_e;

  // Unsigned widths exist only for loads; halves and words must be naturally aligned.
  function automatic logic lsu_access_ok(input logic is_write, input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = !is_write;
      F3_HU:   ok = !is_write && !addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// rtl/lsu_lane_merge.sv - little-endian load lane extraction/extension and store byte/half merge
module lsu_lane_merge
  import lsu_pkg::*;
#(
  parameter int dataW = 32
) (
  input  logic [2:0]       i_funct3,
  input  logic [1:0]       i_addr_lo,
  input  logic [dataW-1:0] i_rd_word,
  input  logic [dataW-1:0] i_rmw_word,
  input  logic [dataW-1:0] i_wdata,
  output logic [dataW-1:0] o_load_data,
  output logic [dataW-1:0] o_store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rd_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rd_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (i_funct3)
      F3_B:    o_load_data = {{(dataW-8){w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{(dataW-16){w_half[15]}}, w_half};
      F3_BU:   o_load_data = {{(dataW-8){1'b0}}, w_byte};
      F3_HU:   o_load_data = {{(dataW-16){1'b0}}, w_half};
      default: o_load_data = i_rd_word;
    endcase
  end

  always_comb begin
    o_store_word = i_rmw_word;
    case (i_funct3)
      F3_B:    o_store_word[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
      F3_H:    o_store_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_store_word = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-request load/store unit with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int dataW       = 32,
  parameter int RAMAddrSize = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [2:0]             funct3,
  input  logic [RAMAddrSize-1:0] addr,
  input  logic [dataW-1:0]       wdata,
  output logic [dataW-1:0]       rdata,
  output logic                   done,
  output logic                   err,
  output logic [RAMAddrSize-1:0] RAMAddr,
  output logic [dataW-1:0]       DataIn,
  output logic                   WriteControl,
  input  logic [dataW-1:0]       DataOut
);

  lsu_state_e             r_state;
  lsu_state_e             w_next_state;
  logic [RAMAddrSize-1:0] r_addr;
  logic [2:0]             r_funct3;
  logic                   r_write;
  logic [dataW-1:0]       r_wdata;
  logic [dataW-1:0]       r_rmw;
  logic [dataW-1:0]       r_rdata;
  logic                   r_err;
  logic                   w_ok;
  logic [RAMAddrSize-1:0] w_word_addr;
  logic [dataW-1:0]       w_load_data;
  logic [dataW-1:0]       w_store_word;

  assign w_ok        = lsu_access_ok(req_write, funct3, addr[1:0]);
  assign w_word_addr = {r_addr[RAMAddrSize-1:2], 2'b00};
  assign rdata       = r_rdata;

  lsu_lane_merge #(.dataW(dataW)) u_lane_merge (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_rd_word    (DataOut),
    .i_rmw_word   (r_rmw),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_store_word (w_store_word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Full-word stores skip the read; rejected requests go straight to DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!w_ok)                          w_next_state = ST_DONE;
          else if (req_write && funct3 == F3_W) w_next_state = ST_WRITE;
          else                                w_next_state = ST_READ;
        end
      end
      ST_READ:  w_next_state = r_write ? ST_WRITE : ST_DONE;
      ST_WRITE: w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    WriteControl = 1'b0;
    RAMAddr      = '0;
    DataIn       = '0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      ST_IDLE:  req_ready = 1'b1;
      ST_READ:  RAMAddr = w_word_addr;
      ST_WRITE: begin
        RAMAddr      = w_word_addr;
        DataIn       = w_store_word;
        WriteControl = 1'b1;
      end
      default: begin
        done = 1'b1;
        err  = r_err;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr   <= '0;
      r_funct3 <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_rmw    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_addr   <= addr;
        r_funct3 <= funct3;
        r_write  <= req_write;
        r_wdata  <= wdata;
        r_err    <= !w_ok;
      end
      if (r_state == ST_READ) begin
        if (r_write) r_rmw   <= DataOut;
        else         r_rdata <= w_load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - vector table plus scoreboard bench for load_store_unit against a model RAM
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic [31:0] RAMAddr;
  logic [31:0] DataIn;
  logic        WriteControl;
  logic [31:0] DataOut;

  logic [31:0] mem [0:63];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = 6'd0;
  logic [31:0] bd_data = 32'd0;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          exp_wc;
    int          chk_idx;
    logic [31:0] exp_word;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          wc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  load_store_unit #(.dataW(32), .RAMAddrSize(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .err(err), .RAMAddr(RAMAddr), .DataIn(DataIn),
    .WriteControl(WriteControl), .DataOut(DataOut)
  );

  always #5 clock = ~clock;

  assign DataOut = mem[RAMAddr[7:2]];

  always @(posedge clock) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    else if (WriteControl) mem[RAMAddr[7:2]] <= DataIn;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clock);
    bd_we = 1'b1; bd_idx = idx[5:0]; bd_data = data;
    @(posedge clock); #1;
    bd_we = 1'b0;
  endtask

  task automatic run(input vec_t v, input int n);
    exp_t e;
    int   cyc;
    int   wc;
    bit   seen;
    @(negedge clock);
    chk($sformatf("v%0d req_ready", n), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.wr; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    sb_q.push_back('{v.exp_rdata, v.exp_err, v.exp_cyc, v.exp_wc});
    @(posedge clock); #1;
    // Keep presenting junk while busy; it must be ignored.
    req_write = $urandom_range(0, 1); funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    cyc = 0; wc = 0; seen = 0;
    while (!seen && cyc < 8) begin
      @(negedge clock);
      cyc++;
      if (WriteControl) wc++;
      if (done) seen = 1;
    end
    req_valid = 1'b0;
    e = sb_q.pop_front();
    if (!seen) begin
      total++; bad++;
      $display("FAIL v%0d timeout actual=no_done required=done", n);
    end else begin
      chk($sformatf("v%0d err", n), {31'd0, err}, {31'd0, e.err});
      chk($sformatf("v%0d cycles", n), cyc, e.cyc);
      chk($sformatf("v%0d writes", n), wc, e.wc);
      @(posedge clock); #1;
      chk($sformatf("v%0d rdata", n), rdata, e.rdata);
      if (v.chk_idx >= 0) chk($sformatf("v%0d ramword", n), mem[v.chk_idx], v.exp_word);
    end
  endtask

  initial begin
    vecs = '{
      '{0, 3'd0, 32'h41, 32'h0,        32'hFFFFFFAA, 0, 2, 0, 16, 32'h8899AABB},
      '{0, 3'd5, 32'h42, 32'h0,        32'h00008899, 0, 2, 0, -1, 32'h0},
      '{0, 3'd2, 32'h40, 32'h0,        32'h8899AABB, 0, 2, 0, -1, 32'h0},
      '{0, 3'd1, 32'h40, 32'h0,        32'hFFFFAABB, 0, 2, 0, -1, 32'h0},
      '{0, 3'd4, 32'h43, 32'h0,        32'h00000088, 0, 2, 0, -1, 32'h0},
      '{1, 3'd1, 32'h41, 32'h5555,     32'h00000088, 1, 1, 0, 16, 32'h8899AABB},
      '{0, 3'd2, 32'h42, 32'h0,        32'h00000088, 1, 1, 0, -1, 32'h0},
      '{0, 3'd3, 32'h40, 32'h0,        32'h00000088, 1, 1, 0, -1, 32'h0},
      '{1, 3'd0, 32'h42, 32'h12,       32'h00000088, 0, 3, 1, 16, 32'h8812AABB},
      '{0, 3'd2, 32'h40, 32'h0,        32'h8812AABB, 0, 2, 0, -1, 32'h0},
      '{1, 3'd1, 32'h40, 32'h1234CAFE, 32'h8812AABB, 0, 3, 1, 16, 32'h8812CAFE},
      '{1, 3'd2, 32'h08, 32'hDEADBEEF, 32'h8812AABB, 0, 2, 1, 2,  32'hDEADBEEF},
      '{0, 3'd0, 32'h08, 32'h0,        32'hFFFFFFEF, 0, 2, 0, -1, 32'h0},
      '{1, 3'd4, 32'h00, 32'hFFFF,     32'hFFFFFFEF, 1, 1, 0, 0,  32'h11223344},
      '{0, 3'd5, 32'h46, 32'h0,        32'h00008001, 0, 2, 0, -1, 32'h0},
      '{0, 3'd0, 32'h45, 32'h0,        32'h0000007F, 0, 2, 0, -1, 32'h0},
      '{1, 3'd0, 32'h03, 32'hFFFFFFA5, 32'h0000007F, 0, 3, 1, 0,  32'hA5223344},
      '{0, 3'd7, 32'h43, 32'h0,        32'h0000007F, 1, 1, 0, -1, 32'h0}
    };

    for (int i = 0; i < 64; i++) poke(i, 32'h0);
    poke(16, 32'h8899AABB);
    poke(17, 32'h80017F00);
    poke(0,  32'h11223344);

    @(negedge clock);
    chk("rst WriteControl", {31'd0, WriteControl}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst RAMAddr", RAMAddr, 32'd0);
    chk("rst DataIn", DataIn, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], i);

    // Reset in the middle of the write phase of a byte store.
    poke(16, 32'h8899AABB);
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; funct3 = 3'd0; addr = 32'h40; wdata = 32'h55;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #1;
    chk("mid WriteControl", {31'd0, WriteControl}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort WriteControl", {31'd0, WriteControl}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    chk("abort RAMAddr", RAMAddr, 32'd0);
    chk("abort DataIn", DataIn, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    chk("abort ramword", mem[16], 32'h8899AABB);
    chk("abort req_ready", {31'd0, req_ready}, 32'd1);
    run('{0, 3'd2, 32'h40, 32'h0, 32'h8899AABB, 0, 2, 0, 16, 32'h8899AABB}, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter dataW, default 32, data word width.
REQ-002 SHALL have parameter RAMAddrSize, default 32, byte-address width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  CPU access request.
REQ-006 SHALL have port req_ready  output  1  unit idle, request accepted this cycle if req_valid.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port funct3  input  3  RV32I width/sign code (0 B, 1 H, 2 W, 4 BU, 5 HU).
REQ-009 SHALL have port addr  input  RAMAddrSize  byte address.
REQ-010 SHALL have port wdata  input  dataW  store data, low bytes used for SB/SH.
REQ-011 SHALL have port rdata  output  dataW  extended load result.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  misaligned or illegal funct3, valid with done.
REQ-014 SHALL have port RAMAddr  output  RAMAddrSize  word-aligned RAM address (addr with bits[1:0]=0).
REQ-015 SHALL have port DataIn  output  dataW  write word to RAM.
REQ-016 SHALL have port WriteControl  output  1  RAM write enable, sampled by RAM at rising edge.
REQ-017 SHALL have port DataOut  input  dataW  zero-delay RAM read word for current RAMAddr.

Function
REQ-018 Request accepted on the edge where req_valid && req_ready; addr, funct3, req_write, wdata latched then; inputs ignored while busy.
REQ-019 req_ready SHALL be 1 only in state IDLE; states: IDLE, READ, WRITE, DONE.
REQ-020 Misaligned (H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0) or illegal funct3 (loads 3,6,7; stores 3..7): IDLE->DONE, err=1, no RAM write, rdata unchanged.
REQ-021 Load: IDLE->READ->DONE; in READ RAMAddr=latched word address; at READ exit edge rdata <= selected byte/half sign- (B,H) or zero-extended (BU,HU), or full word (W); done=1 in DONE (2 cycles after acceptance).
REQ-022 SW: IDLE->WRITE->DONE; WriteControl=1 and DataIn=wdata for the single WRITE cycle.
REQ-023 SB/SH: IDLE->READ->WRITE->DONE; READ captures DataOut; WRITE drives captured word with addressed byte/half replaced by wdata[7:0]/[15:0], WriteControl=1; done at cycle 3.
REQ-024 DONE->IDLE unconditionally; done and err SHALL be 1 only in DONE; back-to-back requests incur one IDLE cycle.
REQ-025 WriteControl SHALL be 0 in every state except WRITE; RAMAddr=0, DataIn=0 in IDLE.
REQ-026 rdata SHALL hold its value until the next successful load completes; stores never alter it.
REQ-027 Byte lanes little-endian: byte k of the word is bits [8k+7:8k], half at addr[1] is bits [16*addr[1]+15:16*addr[1]].
REQ-028 Accesses to word addresses 0..3 (memory-mapped I/O) SHALL be treated identically to RAM; RMW reads of I/O words are permitted.

Reset
REQ-029 reset low SHALL immediately force state IDLE, WriteControl=0, done=0, err=0, rdata=0, RAMAddr=0, DataIn=0, aborting any in-flight access with no RAM write.
REQ-030 After reset release, first request SHALL be accepted on the first rising edge with req_valid=1.

Structure
REQ-031 Package lsu_pkg SHALL hold the funct3 encoding constants and the state enum type.
REQ-032 Combinational sub-module lsu_lane_merge SHALL implement load extraction/extension and store byte/half merge; FSM and registers stay in load_store_unit.

Verification (RAM word at 0x40 preloaded to 0x8899AABB)
REQ-033 LB addr 0x41 -> done at cycle 2, rdata=0xFFFFFFAA, err=0, WriteControl never 1.
REQ-034 LHU addr 0x42 -> rdata=0x00008899; LW 0x40 -> rdata=0x8899AABB.
REQ-035 SB addr 0x42 wdata 0x00000012 -> one READ, one WRITE cycle, RAM word 0x8812AABB, done at cycle 3.
REQ-036 SH addr 0x41 or LW addr 0x42 -> done+err at cycle 1, no WriteControl, rdata unchanged.
REQ-037 SW addr 0x08 wdata 0xDEADBEEF -> UsrOutData1=0xDEADBEEF after WRITE edge.
REQ-038 reset asserted during WRITE of SB 0x40 -> WriteControl drops at once, word stays 0x8899AABB, req_ready=1 after release.
